tiny_dnn_seq: RTL and testbench

TINY_DNN_SEQ -- requirements
Module: tiny_dnn_seq

---
 rtl/tiny_dnn_seq.sv | 135 +++++++++++++
 tb/tb_tiny_dnn_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tiny_dnn_seq.sv
// tiny_dnn_seq: address sequencer for a small dense layer.
// Walks i over the source vector for every output o and emits source/weight read
// addresses with an exec strobe. A delay line then emits one destination write
// strobe per output, OUT_LAT cycles after that output's last exec.
// Optional build macro TINY_DNN_SEQ_STALL_EN adds a stall input that holds the walk.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | issuing exec strobes, one per non-stalled cycle
// DRAIN   | all execs issued, waiting for the final outr/done
module tiny_dnn_seq #(
  parameter int OUT_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] ss_m1,
  input  logic [11:0] ds_m1,
`ifdef TINY_DNN_SEQ_STALL_EN
  input  logic        stall,
`endif
  output logic        busy,
  output logic        done,
  output logic        exec,
  output logic [11:0] ia,
  output logic [23:0] wa,
  output logic        init,
  output logic        outr,
  output logic [11:0] oa
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]         state;
  logic [11:0]        ss;
  logic [11:0]        ds;
  logic [11:0]        o;
  logic               hold;
  logic               row_end;
  logic               run_end;
  logic [OUT_LAT-1:0] dl_vld;
  logic [OUT_LAT-1:0] dl_last;
  logic [11:0]        dl_adr [OUT_LAT];

`ifdef TINY_DNN_SEQ_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // ia doubles as the i counter; wa simply counts up because i walks contiguously.
  assign row_end = (ia == ss);
  assign run_end = row_end && (o == ds);
  assign busy    = (state != S_IDLE);

  // The delay line's final stage drives the write strobe, address and done directly.
  assign outr = dl_vld[OUT_LAT-1];
  assign done = dl_last[OUT_LAT-1];
  assign oa   = dl_adr[OUT_LAT-1];

  // Control FSM and address walk; exec/init are registered alongside the address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ss    <= '0;
      ds    <= '0;
      o     <= '0;
      ia    <= '0;
      wa    <= '0;
      exec  <= 1'b0;
      init  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ss    <= ss_m1;
            ds    <= ds_m1;
            o     <= '0;
            ia    <= '0;
            wa    <= '0;
            exec  <= 1'b1;
            init  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (exec && run_end) begin
            exec  <= 1'b0;
            init  <= 1'b0;
            state <= S_DRAIN;
          end else begin
            // Advance only past an address that was actually issued; a stalled
            // cycle keeps the pending address for the next exec.
            if (exec) begin
              if (row_end) begin
                ia <= '0;
                o  <= o + 12'd1;
              end else begin
                ia <= ia + 12'd1;
              end
              wa <= wa + 24'd1;
            end
            exec <= !hold;
            init <= !hold && (exec ? row_end : (ia == '0));
          end
        end
        S_DRAIN: begin
          if (done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output delay line; shifts every cycle regardless of stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_vld  <= '0;
      dl_last <= '0;
      for (int k = 0; k < OUT_LAT; k++) dl_adr[k] <= '0;
    end else begin
      dl_vld[0]  <= exec && row_end;
      dl_last[0] <= exec && run_end;
      dl_adr[0]  <= o;
      for (int k = 1; k < OUT_LAT; k++) begin
        dl_vld[k]  <= dl_vld[k-1];
        dl_last[k] <= dl_last[k-1];
        dl_adr[k]  <= dl_adr[k-1];
      end
    end
  end

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Bench for tiny_dnn_seq: two instances (OUT_LAT=2 and OUT_LAT=5) share the stimulus,
// and each cycle is compared to a per-run timeline computed from the sequencing rules.
module tb_tiny_dnn_seq;

  localparam int MAXC = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] ss_m1;
  logic [11:0] ds_m1;
`ifdef TINY_DNN_SEQ_STALL_EN
  logic        stall;
`endif
  logic [1:0]  busy_v, done_v, exec_v, init_v, outr_v;
  logic [11:0] ia_v [2];
  logic [23:0] wa_v [2];
  logic [11:0] oa_v [2];

  int tot = 0;
  int bad = 0;
  int lat [2] = '{2, 5};

  bit x_exec [MAXC];
  int x_ia   [MAXC];
  int x_wa   [MAXC];
  bit x_init [MAXC];
  bit x_skip [MAXC];
  bit x_outr [2][MAXC];
  int x_oa   [2][MAXC];
  bit x_done [2][MAXC];
  bit x_busy [2][MAXC];

  always #5 clk = ~clk;

  tiny_dnn_seq #(.OUT_LAT(2)) dut0 (
    .clk(clk), .reset(reset), .start(start), .ss_m1(ss_m1), .ds_m1(ds_m1),
`ifdef TINY_DNN_SEQ_STALL_EN
    .stall(stall),
`endif
    .busy(busy_v[0]), .done(done_v[0]), .exec(exec_v[0]), .ia(ia_v[0]), .wa(wa_v[0]),
    .init(init_v[0]), .outr(outr_v[0]), .oa(oa_v[0])
  );

  tiny_dnn_seq #(.OUT_LAT(5)) dut1 (
    .clk(clk), .reset(reset), .start(start), .ss_m1(ss_m1), .ds_m1(ds_m1),
`ifdef TINY_DNN_SEQ_STALL_EN
    .stall(stall),
`endif
    .busy(busy_v[1]), .done(done_v[1]), .exec(exec_v[1]), .ia(ia_v[1]), .wa(wa_v[1]),
    .init(init_v[1]), .outr(outr_v[1]), .oa(oa_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Build the expected timeline: cycle 1 is the cycle after start is accepted.
  task automatic build_model(input int ss, input int ds, input int st_at, input int st_len,
                             input int abort_at);
    int c;
    int last;
    for (int k = 0; k < MAXC; k++) begin
      x_exec[k] = 0; x_ia[k] = 0; x_wa[k] = 0; x_init[k] = 0;
      x_skip[k] = (k - 1 >= st_at) && (k - 1 < st_at + st_len);
      for (int d = 0; d < 2; d++) begin
        x_outr[d][k] = 0; x_oa[d][k] = 0; x_done[d][k] = 0; x_busy[d][k] = 0;
      end
    end
    c = 1;
    last = 1;
    for (int o = 0; o <= ds; o++) begin
      for (int i = 0; i <= ss; i++) begin
        while (x_skip[c]) c++;
        x_exec[c] = 1;
        x_ia[c]   = i;
        x_wa[c]   = o * (ss + 1) + i;
        x_init[c] = (i == 0);
        if (i == ss) begin
          for (int d = 0; d < 2; d++) begin
            x_outr[d][c + lat[d]] = 1;
            x_oa[d][c + lat[d]]   = o;
          end
        end
        last = c;
        c++;
      end
    end
    for (int d = 0; d < 2; d++) begin
      x_done[d][last + lat[d]] = 1;
      for (int k = 1; k <= last + lat[d]; k++) x_busy[d][k] = 1;
    end
    if (abort_at > 0) begin
      for (int k = abort_at + 1; k < MAXC; k++) begin
        x_exec[k] = 0; x_init[k] = 0;
        for (int d = 0; d < 2; d++) begin
          x_outr[d][k] = 0; x_done[d][k] = 0; x_busy[d][k] = 0;
        end
      end
    end
  endtask

  task automatic run_case(input int ss, input int ds, input int st_at, input int st_len,
                          input int abort_at, input int mid_at);
    int ncyc;
    int last_done;
    build_model(ss, ds, st_at, st_len, abort_at);
    last_done = 0;
    for (int k = 0; k < MAXC; k++) if (x_done[1][k]) last_done = k;
    ncyc = (abort_at > 0) ? abort_at + 20 : last_done + 3;
    if (ncyc > MAXC - 1) ncyc = MAXC - 1;
    @(negedge clk);
    ss_m1 = 12'(ss);
    ds_m1 = 12'(ds);
    start = 1'b1;
    for (int c = 1; c < ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      ss_m1 = 12'(ss);
      ds_m1 = 12'(ds);
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d s%0d/%0d c%0d exec", d, ss, ds, c), exec_v[d], x_exec[c]);
        chk($sformatf("d%0d s%0d/%0d c%0d init", d, ss, ds, c), init_v[d], x_init[c]);
        if (x_exec[c]) begin
          chk($sformatf("d%0d s%0d/%0d c%0d ia", d, ss, ds, c), ia_v[d], x_ia[c]);
          chk($sformatf("d%0d s%0d/%0d c%0d wa", d, ss, ds, c), wa_v[d], x_wa[c]);
        end
        chk($sformatf("d%0d s%0d/%0d c%0d outr", d, ss, ds, c), outr_v[d], x_outr[d][c]);
        if (x_outr[d][c])
          chk($sformatf("d%0d s%0d/%0d c%0d oa", d, ss, ds, c), oa_v[d], x_oa[d][c]);
        chk($sformatf("d%0d s%0d/%0d c%0d done", d, ss, ds, c), done_v[d], x_done[d][c]);
        chk($sformatf("d%0d s%0d/%0d c%0d busy", d, ss, ds, c), busy_v[d], x_busy[d][c]);
      end
`ifdef TINY_DNN_SEQ_STALL_EN
      stall = (c >= st_at) && (c < st_at + st_len);
`endif
      if (c == mid_at) begin
        start = 1'b1;
        ss_m1 = 12'(ss + 2);
        ds_m1 = 12'(ds + 1);
      end
      if (c == abort_at) reset = 1'b1;
    end
`ifdef TINY_DNN_SEQ_STALL_EN
    stall = 1'b0;
`endif
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ss_m1 = '0;
    ds_m1 = '0;
`ifdef TINY_DNN_SEQ_STALL_EN
    stall = 1'b0;
`endif
    repeat (2) @(negedge clk);
    // Start held alongside reset must not launch a run.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset busy", d), busy_v[d], 0);
      chk($sformatf("d%0d reset done", d), done_v[d], 0);
      chk($sformatf("d%0d reset exec", d), exec_v[d], 0);
      chk($sformatf("d%0d reset init", d), init_v[d], 0);
      chk($sformatf("d%0d reset outr", d), outr_v[d], 0);
      chk($sformatf("d%0d reset ia", d), ia_v[d], 0);
      chk($sformatf("d%0d reset wa", d), wa_v[d], 0);
      chk($sformatf("d%0d reset oa", d), oa_v[d], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    run_case(3, 1, 0, 0, -1, -1);
    run_case(0, 0, 0, 0, -1, -1);
    run_case(3, 1, 0, 0, -1, 3);
    run_case(7, 1, 0, 0, 5, -1);
    run_case(1, 2, 0, 0, -1, -1);
    run_case(0, 3, 0, 0, -1, -1);
`ifdef TINY_DNN_SEQ_STALL_EN
    run_case(2, 0, 2, 2, -1, -1);
    for (int r = 0; r < 6; r++)
      run_case(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
               int'($urandom_range(1, 8)), int'($urandom_range(0, 3)), -1, -1);
`else
    for (int r = 0; r < 6; r++)
      run_case(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 0, 0, -1, -1);
`endif

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
